// File: rtl/atm_pkg.sv
// Shared encodings for the ATM transaction controller: FSM states, op codes, error codes.
package atm_pkg;

  typedef enum logic [2:0] {
    S_CHK_ACC = 3'd0,
    S_CHK_PIN = 3'd1,
    S_EXEC    = 3'd2,
    S_RESULT  = 3'd3,
    S_IDLE    = 3'd7
  } state_e;

  localparam logic [2:0] OP_BAL   = 3'd3;
  localparam logic [2:0] OP_WD    = 3'd4;
  localparam logic [2:0] OP_DEP   = 3'd5;
  localparam logic [2:0] OP_CHPIN = 3'd6;

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_ACCT = 3'd1;
  localparam logic [2:0] ERR_PIN  = 3'd2;
  localparam logic [2:0] ERR_LOCK = 3'd3;
  localparam logic [2:0] ERR_FUND = 3'd4;
  localparam logic [2:0] ERR_OVF  = 3'd5;
  localparam logic [2:0] ERR_SAME = 3'd6;
  localparam logic [2:0] ERR_OP   = 3'd7;

  function automatic logic op_valid(input logic [2:0] op);
    return (op >= OP_BAL) && (op <= OP_CHPIN);
  endfunction

endpackage

// File: rtl/atm_acct_db.sv
// Account database: per-account PIN, balance, wrong-PIN counter and lock flag.
// One combinational read port, one transaction update port, one boot load port.
module atm_acct_db #(
  parameter int NUM_ACC = 16,
  parameter int PIN_W   = 16,
  parameter int BAL_W   = 32,
  parameter int TRY_W   = 2,
  parameter int ACC_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] i_rd_idx,
  output logic [PIN_W-1:0] o_rd_pin,
  output logic [BAL_W-1:0] o_rd_bal,
  output logic [TRY_W-1:0] o_rd_try,
  output logic             o_rd_lock,
  input  logic [ACC_W-1:0] i_up_idx,
  input  logic             i_up_pin_we,
  input  logic [PIN_W-1:0] i_up_pin,
  input  logic             i_up_bal_we,
  input  logic [BAL_W-1:0] i_up_bal,
  input  logic             i_up_try_we,
  input  logic [TRY_W-1:0] i_up_try,
  input  logic             i_up_lock,
  input  logic             i_ld_we,
  input  logic [ACC_W-1:0] i_ld_idx,
  input  logic [PIN_W-1:0] i_ld_pin,
  input  logic [BAL_W-1:0] i_ld_bal
);

  logic [NUM_ACC-1:0][PIN_W-1:0] w_pin;
  logic [NUM_ACC-1:0][BAL_W-1:0] w_bal;
  logic [NUM_ACC-1:0][TRY_W-1:0] w_try;
  logic [NUM_ACC-1:0]            w_lock;

  // Index comparison against g+1 also rejects index 0 and anything past NUM_ACC.
  for (genvar g = 0; g < NUM_ACC; g++) begin : g_acc
    logic [PIN_W-1:0] r_pin;
    logic [BAL_W-1:0] r_bal;
    logic [TRY_W-1:0] r_try;
    logic             r_lock;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pin  <= '0;
        r_bal  <= '0;
        r_try  <= '0;
        r_lock <= 1'b0;
      end else if (i_ld_we && i_ld_idx == ACC_W'(g + 1)) begin
        r_pin  <= i_ld_pin;
        r_bal  <= i_ld_bal;
        r_try  <= '0;
        r_lock <= 1'b0;
      end else if (i_up_idx == ACC_W'(g + 1)) begin
        if (i_up_pin_we) r_pin <= i_up_pin;
        if (i_up_bal_we) r_bal <= i_up_bal;
        if (i_up_try_we) begin
          r_try  <= i_up_try;
          r_lock <= i_up_lock;
        end
      end
    end

    assign w_pin[g]  = r_pin;
    assign w_bal[g]  = r_bal;
    assign w_try[g]  = r_try;
    assign w_lock[g] = r_lock;
  end

  always_comb begin
    o_rd_pin  = '0;
    o_rd_bal  = '0;
    o_rd_try  = '0;
    o_rd_lock = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (i_rd_idx == ACC_W'(i + 1)) begin
        o_rd_pin  = w_pin[i];
        o_rd_bal  = w_bal[i];
        o_rd_try  = w_try[i];
        o_rd_lock = w_lock[i];
      end
    end
  end

endmodule

// File: rtl/atm_multi_ctrl.sv
// ATM transaction controller: IDLE -> CHK_ACC -> CHK_PIN -> EXEC -> RESULT, with early
// exit to RESULT on any failure; done pulses the cycle after RESULT.
module atm_multi_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACC   = 16,
  parameter int PIN_W     = 16,
  parameter int BAL_W     = 32,
  parameter int MAX_TRIES = 3,
  localparam int ACC_W    = $clog2(NUM_ACC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] new_pin,
  input  logic [BAL_W-1:0] amount,
  input  logic             language,
  input  logic             db_we,
  input  logic [ACC_W-1:0] db_idx,
  input  logic [PIN_W-1:0] db_pin,
  input  logic [BAL_W-1:0] db_bal,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic [2:0]       err_code,
  output logic [BAL_W-1:0] balance,
  output logic             locked,
  output logic             lang,
  output logic [2:0]       state
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_e           r_state;
  logic [2:0]       r_op;
  logic [ACC_W-1:0] r_acc;
  logic [PIN_W-1:0] r_pin, r_new_pin;
  logic [BAL_W-1:0] r_amt;
  logic             r_busy, r_done, r_success, r_locked, r_lang;
  logic [2:0]       r_err;
  logic [BAL_W-1:0] r_balance;

  logic [PIN_W-1:0] w_rd_pin;
  logic [BAL_W-1:0] w_rd_bal;
  logic [TRY_W-1:0] w_rd_try;
  logic             w_rd_lock;

  logic             w_fin;
  logic [2:0]       w_err;
  logic [BAL_W-1:0] w_bal;
  logic             w_lck;
  logic             w_pin_we, w_bal_we, w_try_we, w_up_lock;
  logic [TRY_W-1:0] w_up_try;
  logic [TRY_W:0]   w_try_inc;
  logic [BAL_W:0]   w_sum;
  logic             w_acc_ok, w_ld_we;

  assign w_acc_ok  = (r_acc != '0) && (r_acc <= ACC_W'(NUM_ACC));
  assign w_try_inc = {1'b0, w_rd_try} + 1'b1;
  assign w_sum     = {1'b0, w_rd_bal} + {1'b0, r_amt};
  assign w_ld_we   = db_we && (r_state == S_IDLE);

  atm_acct_db #(
    .NUM_ACC(NUM_ACC), .PIN_W(PIN_W), .BAL_W(BAL_W), .TRY_W(TRY_W), .ACC_W(ACC_W)
  ) u_db (
    .clk        (clk),
    .rst_n      (rst),
    .i_rd_idx   (r_acc),
    .o_rd_pin   (w_rd_pin),
    .o_rd_bal   (w_rd_bal),
    .o_rd_try   (w_rd_try),
    .o_rd_lock  (w_rd_lock),
    .i_up_idx   (r_acc),
    .i_up_pin_we(w_pin_we),
    .i_up_pin   (r_new_pin),
    .i_up_bal_we(w_bal_we),
    .i_up_bal   (w_bal),
    .i_up_try_we(w_try_we),
    .i_up_try   (w_up_try),
    .i_up_lock  (w_up_lock),
    .i_ld_we    (w_ld_we),
    .i_ld_idx   (db_idx),
    .i_ld_pin   (db_pin),
    .i_ld_bal   (db_bal)
  );

  // Per-state decision: whether to finish now, the result to report, and any db update.
  always_comb begin
    w_fin     = 1'b0;
    w_err     = ERR_OK;
    w_bal     = w_rd_bal;
    w_lck     = w_rd_lock;
    w_pin_we  = 1'b0;
    w_bal_we  = 1'b0;
    w_try_we  = 1'b0;
    w_up_try  = '0;
    w_up_lock = 1'b0;
    case (r_state)
      S_CHK_ACC: begin
        if (!w_acc_ok) begin
          w_fin = 1'b1;
          w_err = ERR_ACCT;
          w_bal = '0;
          w_lck = 1'b0;
        end else if (w_rd_lock) begin
          w_fin = 1'b1;
          w_err = ERR_LOCK;
        end else if (!op_valid(r_op)) begin
          w_fin = 1'b1;
          w_err = ERR_OP;
        end
      end
      S_CHK_PIN: begin
        w_try_we = 1'b1;
        if (r_pin != w_rd_pin) begin
          w_fin     = 1'b1;
          w_err     = ERR_PIN;
          w_up_try  = w_try_inc[TRY_W-1:0];
          w_up_lock = (w_try_inc >= (TRY_W + 1)'(MAX_TRIES));
          w_lck     = w_up_lock;
        end
      end
      S_EXEC: begin
        w_fin = 1'b1;
        case (r_op)
          OP_BAL: ;
          OP_WD: begin
            if (r_amt > w_rd_bal) w_err = ERR_FUND;
            else begin
              w_bal_we = 1'b1;
              w_bal    = w_rd_bal - r_amt;
            end
          end
          OP_DEP: begin
            if (w_sum[BAL_W]) w_err = ERR_OVF;
            else begin
              w_bal_we = 1'b1;
              w_bal    = w_sum[BAL_W-1:0];
            end
          end
          OP_CHPIN: begin
            if (r_new_pin == w_rd_pin) w_err = ERR_SAME;
            else w_pin_we = 1'b1;
          end
          default: w_err = ERR_OP;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_acc     <= '0;
      r_pin     <= '0;
      r_new_pin <= '0;
      r_amt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_success <= 1'b0;
      r_err     <= ERR_OK;
      r_balance <= '0;
      r_locked  <= 1'b0;
      r_lang    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A load in the same cycle takes priority; the start is dropped.
          if (!db_we && start) begin
            r_op      <= operation;
            r_acc     <= acc_num;
            r_pin     <= pin;
            r_new_pin <= new_pin;
            r_amt     <= amount;
            r_lang    <= language;
            r_busy    <= 1'b1;
            r_state   <= S_CHK_ACC;
          end
        end
        S_CHK_ACC, S_CHK_PIN, S_EXEC: begin
          if (w_fin) begin
            r_success <= (w_err == ERR_OK);
            r_err     <= w_err;
            r_balance <= w_bal;
            r_locked  <= w_lck;
            r_state   <= S_RESULT;
          end else begin
            r_state <= (r_state == S_CHK_ACC) ? S_CHK_PIN : S_EXEC;
          end
        end
        S_RESULT: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign success  = r_success;
  assign err_code = r_err;
  assign balance  = r_balance;
  assign locked   = r_locked;
  assign lang     = r_lang;
  assign state    = r_state;

endmodule

// File: tb/tb_atm_multi_ctrl.sv
// Directed bench for atm_multi_ctrl: load, transactions, lockout, errors, reset and handshake.
module tb_atm_multi_ctrl;

  logic        clk, rst, start, language, db_we;
  logic [2:0]  operation;
  logic [4:0]  acc_num, db_idx;
  logic [15:0] pin, new_pin, db_pin;
  logic [31:0] amount, db_bal;
  logic        busy, done, success, locked, lang;
  logic [2:0]  err_code, state;
  logic [31:0] balance;

  int checks = 0;
  int errors = 0;

  atm_multi_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation), .acc_num(acc_num),
    .pin(pin), .new_pin(new_pin), .amount(amount), .language(language),
    .db_we(db_we), .db_idx(db_idx), .db_pin(db_pin), .db_bal(db_bal),
    .busy(busy), .done(done), .success(success), .err_code(err_code),
    .balance(balance), .locked(locked), .lang(lang), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load(input logic [4:0] idx, input logic [15:0] p, input logic [31:0] b);
    @(negedge clk);
    db_we = 1'b1; db_idx = idx; db_pin = p; db_bal = b;
    @(posedge clk); #1;
    db_we = 1'b0;
  endtask

  // Issues one start and returns the number of edges until done was seen.
  task automatic txn(input logic [2:0] op, input logic [4:0] acc, input logic [15:0] p,
                     input logic [15:0] np, input logic [31:0] amt, input logic lg,
                     output int cyc);
    @(negedge clk);
    operation = op; acc_num = acc; pin = p; new_pin = np; amount = amt; language = lg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL txn_timeout done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset;
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL rst_state got %0d exp 7", state); end
    checks++;
    if ({busy, done, success, locked, lang} !== 5'b0 || err_code !== 3'd0 || balance !== 32'd0) begin
      errors++;
      $display("FAIL rst_outputs busy=%b done=%b succ=%b lck=%b lang=%b err=%0d bal=%0d exp all 0",
               busy, done, success, locked, lang, err_code, balance);
    end
  endtask

  task automatic test_balance;
    int c;
    load(5'd1, 16'd1234, 32'd5000);
    txn(3'd3, 5'd1, 16'd1234, 16'd0, 32'd0, 1'b1, c);
    checks++; if (c !== 4) begin errors++; $display("FAIL bal_latency got %0d exp 4", c); end
    checks++;
    if (success !== 1'b1 || err_code !== 3'd0 || balance !== 32'd5000) begin
      errors++; $display("FAIL bal_result succ=%b err=%0d bal=%0d exp 1/0/5000", success, err_code, balance);
    end
    checks++; if (lang !== 1'b1) begin errors++; $display("FAIL bal_lang got %b exp 1", lang); end
    checks++; if (busy !== 1'b0 || state !== 3'd7) begin errors++; $display("FAIL bal_idle busy=%b state=%0d exp 0/7", busy, state); end
  endtask

  task automatic test_withdraw;
    int c;
    txn(3'd4, 5'd1, 16'd1234, 16'd0, 32'd5100, 1'b0, c);
    checks++;
    if (success !== 1'b0 || err_code !== 3'd4 || balance !== 32'd5000) begin
      errors++; $display("FAIL wd_over succ=%b err=%0d bal=%0d exp 0/4/5000", success, err_code, balance);
    end
    checks++; if (lang !== 1'b0) begin errors++; $display("FAIL wd_lang got %b exp 0", lang); end
    txn(3'd4, 5'd1, 16'd1234, 16'd0, 32'd5000, 1'b0, c);
    checks++;
    if (success !== 1'b1 || err_code !== 3'd0 || balance !== 32'd0) begin
      errors++; $display("FAIL wd_exact succ=%b err=%0d bal=%0d exp 1/0/0", success, err_code, balance);
    end
  endtask

  task automatic test_deposit;
    int c;
    load(5'd2, 16'd1, 32'hFFFF_FFF6);
    txn(3'd5, 5'd2, 16'd1, 16'd0, 32'd10, 1'b0, c);
    checks++;
    if (success !== 1'b0 || err_code !== 3'd5 || balance !== 32'hFFFF_FFF6) begin
      errors++; $display("FAIL dep_ovf succ=%b err=%0d bal=%h exp 0/5/fffffff6", success, err_code, balance);
    end
    txn(3'd5, 5'd2, 16'd1, 16'd0, 32'd9, 1'b0, c);
    checks++;
    if (success !== 1'b1 || err_code !== 3'd0 || balance !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dep_max succ=%b err=%0d bal=%h exp 1/0/ffffffff", success, err_code, balance);
    end
    txn(3'd5, 5'd2, 16'd1, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (success !== 1'b1 || balance !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dep_zero succ=%b bal=%h exp 1/ffffffff", success, balance);
    end
  endtask

  task automatic test_lock;
    int c;
    logic [2:0] exp_lck;
    exp_lck = 3'b100;
    load(5'd3, 16'd42, 32'd100);
    for (int i = 0; i < 3; i++) begin
      txn(3'd3, 5'd3, 16'd41, 16'd0, 32'd0, 1'b0, c);
      checks++;
      if (err_code !== 3'd2 || success !== 1'b0 || locked !== exp_lck[i]) begin
        errors++; $display("FAIL lock_wrong%0d err=%0d succ=%b lck=%b exp 2/0/%b", i, err_code, success, locked, exp_lck[i]);
      end
    end
    txn(3'd3, 5'd3, 16'd42, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (err_code !== 3'd3 || locked !== 1'b1 || c !== 2) begin
      errors++; $display("FAIL lock_right err=%0d lck=%b cyc=%0d exp 3/1/2", err_code, locked, c);
    end
    load(5'd3, 16'd42, 32'd100);
    txn(3'd3, 5'd3, 16'd42, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (success !== 1'b1 || locked !== 1'b0 || balance !== 32'd100) begin
      errors++; $display("FAIL lock_reload succ=%b lck=%b bal=%0d exp 1/0/100", success, locked, balance);
    end
    // A correct PIN clears the counter, so two more misses must not lock.
    load(5'd4, 16'd7, 32'd1);
    txn(3'd3, 5'd4, 16'd8, 16'd0, 32'd0, 1'b0, c);
    txn(3'd3, 5'd4, 16'd8, 16'd0, 32'd0, 1'b0, c);
    txn(3'd3, 5'd4, 16'd7, 16'd0, 32'd0, 1'b0, c);
    txn(3'd3, 5'd4, 16'd8, 16'd0, 32'd0, 1'b0, c);
    txn(3'd3, 5'd4, 16'd8, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (err_code !== 3'd2 || locked !== 1'b0) begin
      errors++; $display("FAIL lock_clear err=%0d lck=%b exp 2/0", err_code, locked);
    end
  endtask

  task automatic test_errors;
    int c;
    txn(3'd3, 5'd0, 16'd1234, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (err_code !== 3'd1 || balance !== 32'd0 || c !== 2) begin
      errors++; $display("FAIL acct0 err=%0d bal=%0d cyc=%0d exp 1/0/2", err_code, balance, c);
    end
    txn(3'd3, 5'd2, 16'd1, 16'd0, 32'd0, 1'b0, c);
    txn(3'd3, 5'd17, 16'd1234, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (err_code !== 3'd1 || balance !== 32'd0) begin
      errors++; $display("FAIL acct17 err=%0d bal=%0d exp 1/0", err_code, balance);
    end
    txn(3'd7, 5'd1, 16'd1234, 16'd0, 32'd0, 1'b0, c);
    checks++; if (err_code !== 3'd7 || success !== 1'b0) begin errors++; $display("FAIL bad_op err=%0d succ=%b exp 7/0", err_code, success); end
    txn(3'd6, 5'd1, 16'd1234, 16'd1234, 32'd0, 1'b0, c);
    checks++; if (err_code !== 3'd6) begin errors++; $display("FAIL same_pin err=%0d exp 6", err_code); end
    txn(3'd6, 5'd1, 16'd1234, 16'd5678, 32'd0, 1'b0, c);
    checks++; if (err_code !== 3'd0 || success !== 1'b1) begin errors++; $display("FAIL chpin err=%0d succ=%b exp 0/1", err_code, success); end
    txn(3'd3, 5'd1, 16'd5678, 16'd0, 32'd0, 1'b0, c);
    checks++; if (err_code !== 3'd0 || success !== 1'b1) begin errors++; $display("FAIL newpin_ok err=%0d succ=%b exp 0/1", err_code, success); end
    txn(3'd3, 5'd1, 16'd1234, 16'd0, 32'd0, 1'b0, c);
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL oldpin_rej err=%0d exp 2", err_code); end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    logic busy_mid = 1'b0;
    @(negedge clk);
    operation = 3'd3; acc_num = 5'd2; pin = 16'd1; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
      if (k == 1) busy_mid = busy;
      if (k == 4) start = 1'b0;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL held_start dones=%0d exp 1", ndone); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL held_busy got %b exp 1", busy_mid); end
    checks++; if (balance !== 32'hFFFF_FFFF) begin errors++; $display("FAIL held_bal got %h exp ffffffff", balance); end
  endtask

  task automatic test_load_vs_start;
    int c;
    int ndone = 0;
    @(negedge clk);
    db_we = 1'b1; db_idx = 5'd5; db_pin = 16'd9; db_bal = 32'd77;
    operation = 3'd3; acc_num = 5'd5; pin = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    db_we = 1'b0; start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0 || state !== 3'd7) begin errors++; $display("FAIL ld_start dones=%0d state=%0d exp 0/7", ndone, state); end
    txn(3'd3, 5'd5, 16'd9, 16'd0, 32'd0, 1'b0, c);
    checks++; if (success !== 1'b1 || balance !== 32'd77) begin errors++; $display("FAIL ld_start_bal succ=%b bal=%0d exp 1/77", success, balance); end
  endtask

  task automatic test_reset_mid;
    int c;
    @(negedge clk);
    operation = 3'd5; acc_num = 5'd1; pin = 16'd5678; amount = 32'd1; language = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL mid_exec state=%0d exp 2", state); end
    rst = 1'b0;
    #1;
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL mid_rst_state got %0d exp 7", state); end
    checks++;
    if ({busy, done, success, locked, lang} !== 5'b0 || err_code !== 3'd0 || balance !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst_outputs busy=%b done=%b succ=%b lck=%b lang=%b err=%0d bal=%0d exp all 0",
               busy, done, success, locked, lang, err_code, balance);
    end
    @(negedge clk);
    rst = 1'b1;
    txn(3'd3, 5'd1, 16'd0, 16'd0, 32'd0, 1'b0, c);
    checks++;
    if (success !== 1'b1 || balance !== 32'd0) begin
      errors++; $display("FAIL mid_rst_db succ=%b bal=%0d exp 1/0", success, balance);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; db_we = 1'b0; language = 1'b0;
    operation = '0; acc_num = '0; pin = '0; new_pin = '0; amount = '0;
    db_idx = '0; db_pin = '0; db_bal = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    test_balance;
    test_withdraw;
    test_deposit;
    test_lock;
    test_errors;
    test_back_to_back;
    test_load_vs_start;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
